pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: CHUNK result bits resolved per stage behind one operand-capture rank.
// Optional saturation on signed overflow is enabled by defining PIPE_ADDSUB_SAT_EN.
module pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overFlow,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_param_check
        $error("pipe_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Rank k holds the operation waiting for stage k to resolve chunk k.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] cy_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    logic [WIDTH-1:0]  stg_s [STAGES];
    logic [STAGES-1:0] stg_c;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_q;
    logic              carry_q;
    logic              ovf_q;
    logic              zero_q;
    logic [TAG_W-1:0]  out_tag_q;

    logic [WIDTH-1:0]  sum_c;
    logic [WIDTH-1:0]  res_c;
    logic              cout_c;
    logic              ovf_c;
    logic              adv;

    // Carry-lookahead add of one chunk; returns {carry_out, sum}.
    function automatic logic [CHUNK:0] cla_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c0);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             t;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 1; i <= CHUNK; i++) begin
            t = c0;
            for (int unsigned j = 0; j < i; j++) t = t & p[j];
            c[i] = t;
            for (int unsigned j = 0; j < i; j++) begin
                t = g[j];
                for (int unsigned k = j + 1; k < i; k++) t = t & p[k];
                c[i] = c[i] | t;
            end
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        stg_c = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stg_s[k] = s_q[k];
            {stg_c[k], stg_s[k][k*CHUNK +: CHUNK]} =
                cla_add(a_q[k][k*CHUNK +: CHUNK], b_q[k][k*CHUNK +: CHUNK], cy_q[k]);
        end
    end

    // Final flags; a_q keeps the true inA so its sign selects the saturation value.
    always_comb begin
        sum_c  = stg_s[LAST];
        cout_c = stg_c[LAST];
        ovf_c  = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ sum_c[WIDTH-1] ^ cout_c;
        res_c  = sum_c;
`ifdef PIPE_ADDSUB_SAT_EN
        if (ovf_c) begin
            res_c = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        vld_d    = '0;
        cy_d     = '0;
        vld_d[0] = in_valid;
        cy_d[0]  = cin;
        a_d[0]   = inA;
        b_d[0]   = inB ^ {WIDTH{mode}};
        s_d[0]   = '0;
        tag_d[0] = in_tag;
        for (int unsigned k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            cy_d[k]  = stg_c[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_d[k]   = stg_s[k-1];
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            cy_q        <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_tag_q   <= '0;
        end else if (adv) begin
            vld_q       <= vld_d;
            cy_q        <= cy_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                tag_q[k] <= tag_d[k];
            end
            out_valid_q <= vld_q[LAST];
            out_q       <= res_c;
            carry_q     <= cout_c;
            ovf_q       <= ovf_c;
            zero_q      <= (res_c == '0);
            out_tag_q   <= tag_q[LAST];
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry     = carry_q;
    assign overFlow  = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = out_tag_q;

endmodule
